herv_rf_sched: RTL



---
 rtl/herv_rf_pkg.sv | 50 +++++
 rtl/herv_rf_sched.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/herv_rf_pkg.sv
// herv_rf_pkg: shared sizing functions, FSM state encoding and the RAM
// address helper for the RF scheduler.
//   calc_n/cw/lg/rw/aw : derived widths from chunk width W and WITH_CSR
//   state_e            : scheduler FSM states
//   mk_addr            : {reg, chunk} RAM address with a variable chunk field
package herv_rf_pkg;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_FLUSH = 2'd2
    } state_e;

    // Widest possible RAM address: 6-bit register + 5-bit chunk (W=1).
    localparam int AW_MAX = 11;

    function automatic int calc_n(input int w);
        return 32 / w;
    endfunction

    // Number of chunk bits actually placed in the RAM address (0 for W=32).
    function automatic int calc_lg(input int w);
        return $clog2(32 / w);
    endfunction

    // Counter width never collapses below one bit so W=32 still has a
    // (constant-zero) counter register.
    function automatic int calc_cw(input int w);
        return (32 / w <= 1) ? 1 : $clog2(32 / w);
    endfunction

    function automatic int calc_rw(input int with_csr);
        return 5 + with_csr;
    endfunction

    function automatic int calc_aw(input int w, input int with_csr);
        return 5 + with_csr + $clog2(32 / w);
    endfunction

    // Chunk bits above lg are masked off, so a 1-bit counter with lg=0
    // contributes nothing to the address.
    function automatic logic [AW_MAX-1:0] mk_addr(input logic [5:0] rg,
                                                  input logic [4:0] ck,
                                                  input int         lg);
        logic [AW_MAX-1:0] m;
        m = (AW_MAX'(1) << lg) - AW_MAX'(1);
        return (AW_MAX'(rg) << lg) | (AW_MAX'(ck) & m);
    endfunction

endpackage

// File: rtl/herv_rf_sched.sv
// herv_rf_sched: time-multiplexes two logical RF read ports and two logical
// write ports onto one RAM read port and one RAM write port. Each W-bit
// chunk takes two RAM cycles; a full 32-bit register pair moves in N=32/W
// chunks, and a transaction lasts 2N+2 cycles (RUN for 2N+1, FLUSH for 1).
//
// Ports:
//   clk, i_rst               clock, async active-high reset
//   i_start, i_rreg0/1       start request and read registers (IDLE only)
//   o_busy, o_done           transaction in progress / final-cycle pulse
//   o_cnt_en, o_rdata0/1     chunk strobe and the read chunks it qualifies
//   i_wen0/1, i_wreg0/1,
//   i_wdata0/1               write ports, sampled while o_cnt_en=1
//   o_raddr, o_ren, i_rdata  RAM read port (1-cycle registered latency)
//   o_waddr, o_wdata, o_wen  RAM write port
module herv_rf_sched
    import herv_rf_pkg::*;
#(
    parameter  int W        = 8,
    parameter  int WITH_CSR = 1,
    localparam int N        = calc_n(W),
    localparam int CW       = calc_cw(W),
    localparam int LG       = calc_lg(W),
    localparam int RW       = calc_rw(WITH_CSR),
    localparam int AW       = calc_aw(W, WITH_CSR)
) (
    input  logic          clk,
    input  logic          i_rst,
    input  logic          i_start,
    input  logic [RW-1:0] i_rreg0,
    input  logic [RW-1:0] i_rreg1,
    output logic          o_busy,
    output logic          o_done,
    output logic          o_cnt_en,
    output logic [W-1:0]  o_rdata0,
    output logic [W-1:0]  o_rdata1,
    input  logic          i_wen0,
    input  logic [RW-1:0] i_wreg0,
    input  logic [W-1:0]  i_wdata0,
    input  logic          i_wen1,
    input  logic [RW-1:0] i_wreg1,
    input  logic [W-1:0]  i_wdata1,
    output logic [AW-1:0] o_raddr,
    output logic          o_ren,
    input  logic [W-1:0]  i_rdata,
    output logic [AW-1:0] o_waddr,
    output logic [W-1:0]  o_wdata,
    output logic          o_wen
);

    localparam logic [CW-1:0] K_LAST = CW'(N - 1);

    state_e        r_state;
    logic          r_busy;
    logic          r_done;
    logic          r_ph;        // 0: rreg0 slot / strobe, 1: rreg1 slot / port-1 write
    logic [CW-1:0] r_k;         // chunk being read this pair
    logic          r_started;   // first read pair issued (t>=2)
    logic          r_rd_done;   // all 2N reads issued (t>=2N)
    logic [RW-1:0] r_rreg0;
    logic [RW-1:0] r_rreg1;
    logic [W-1:0]  r_rbuf0;

    // Port-1 write is deferred one cycle behind the strobe.
    logic          r_w1_pend;
    logic          r_w1_en;
    logic [RW-1:0] r_w1_reg;
    logic [W-1:0]  r_w1_data;
    logic [CW-1:0] r_w1_k;

    logic          w_run;
    logic          w_strobe;
    logic          w_ren;
    logic [CW-1:0] w_sk;
    logic [RW-1:0] w_rreg;

    assign w_run    = (r_state == S_RUN);
    assign w_strobe = w_run & ~r_ph & r_started;
    assign w_ren    = w_run & ~r_rd_done;
    // The strobe trails the reads by one pair, so its chunk is r_k-1;
    // wrap-around covers the final strobe after r_k has returned to 0.
    assign w_sk     = r_k - CW'(1);
    assign w_rreg   = r_ph ? r_rreg1 : r_rreg0;

    assign o_busy   = r_busy;
    assign o_done   = r_done;
    assign o_cnt_en = w_strobe;
    assign o_ren    = w_ren;
    assign o_raddr  = w_ren ? AW'(mk_addr(6'(w_rreg), 5'(r_k), LG)) : '0;
    assign o_rdata0 = w_strobe ? r_rbuf0 : '0;
    assign o_rdata1 = w_strobe ? i_rdata : '0;

    always_comb begin
        o_wen   = 1'b0;
        o_waddr = '0;
        o_wdata = '0;
        if (w_strobe) begin
            o_wen   = i_wen0;
            o_waddr = AW'(mk_addr(6'(i_wreg0), 5'(w_sk), LG));
            o_wdata = i_wdata0;
        end else if (r_w1_pend) begin
            o_wen   = r_w1_en;
            o_waddr = AW'(mk_addr(6'(r_w1_reg), 5'(r_w1_k), LG));
            o_wdata = r_w1_data;
        end
    end

    always_ff @(posedge clk or posedge i_rst) begin
        if (i_rst) begin
            r_state   <= S_IDLE;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_ph      <= 1'b0;
            r_k       <= '0;
            r_started <= 1'b0;
            r_rd_done <= 1'b0;
            r_rreg0   <= '0;
            r_rreg1   <= '0;
            r_rbuf0   <= '0;
            r_w1_pend <= 1'b0;
            r_w1_en   <= 1'b0;
            r_w1_reg  <= '0;
            r_w1_data <= '0;
            r_w1_k    <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (i_start) begin
                        r_state   <= S_RUN;
                        r_busy    <= 1'b1;
                        r_rreg0   <= i_rreg0;
                        r_rreg1   <= i_rreg1;
                        r_k       <= '0;
                        r_ph      <= 1'b0;
                        r_started <= 1'b0;
                        r_rd_done <= 1'b0;
                    end
                end
                S_RUN: begin
                    r_ph <= ~r_ph;
                    if (r_ph) begin
                        // Data for the rreg0 read of the previous cycle.
                        r_rbuf0   <= i_rdata;
                        r_started <= 1'b1;
                        if (r_k == K_LAST) begin
                            r_k       <= '0;
                            r_rd_done <= 1'b1;
                        end else begin
                            r_k <= r_k + CW'(1);
                        end
                    end else if (r_rd_done) begin
                        // Last strobe this cycle; next cycle carries the
                        // final port-1 write.
                        r_state <= S_FLUSH;
                        r_done  <= 1'b1;
                    end
                end
                S_FLUSH: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                end
                default: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                end
            endcase

            r_w1_pend <= w_strobe;
            if (w_strobe) begin
                r_w1_en   <= i_wen1;
                r_w1_reg  <= i_wreg1;
                r_w1_data <= i_wdata1;
                r_w1_k    <= w_sk;
            end
        end
    end

endmodule
